// File: rtl/password_pkg.sv
// Shared constants and types for the password validator/programmer pair.
//   DIGITS    : password length in digits
//   DIGIT_W   : bits per BCD digit
//   IDX_W     : digit index width
//   MAX_DIGIT : largest legal keypad digit
//   ProgState : programming FSM state encoding (also exported on dbgState)
package password_pkg;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MAX_DIGIT = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_SECOND = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } ProgState;

endpackage

// File: rtl/password_regfile.sv
// Password store: DIGITS x DIGIT_W registers, reset to INIT_PW, write-all port,
// combinational read port.
//   CLK, RST : clock, asynchronous active-low reset
//   we       : load every digit from wdata this edge
//   wdata    : new password, digit i at wdata[DIGIT_W*i +: DIGIT_W]
//   address  : read digit index
//   data     : store[address], zero latency
module password_regfile
  import password_pkg::*;
#(
  parameter logic [DIGITS*DIGIT_W-1:0] INIT_PW = '0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      we,
  input  logic [DIGITS*DIGIT_W-1:0] wdata,
  input  logic [IDX_W-1:0]          address,
  output logic [DIGIT_W-1:0]        data
);

  logic [DIGIT_W-1:0] r_mem [DIGITS];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DIGITS; i++) r_mem[i] <= INIT_PW[DIGIT_W*i +: DIGIT_W];
    end else if (we) begin
      for (int i = 0; i < DIGITS; i++) r_mem[i] <= wdata[DIGIT_W*i +: DIGIT_W];
    end
  end

  assign data = r_mem[address];

endmodule

// File: rtl/password_programmer.sv
// Password programmer: owns the password store and serves the validator's read
// port. A new password is typed twice; it is committed only if both entries agree
// and every digit is a legal BCD value.
//   CLK, RST   : clock, asynchronous active-low reset
//   enable     : keypad strobe, digit valid this cycle
//   digit      : keypad digit
//   prog       : start/restart programming ("program" is a reserved word)
//   abort      : discard entry, return to idle (beats prog and enable)
//   address    : validator read address
//   data       : store[address], combinational
//   busy       : entry or commit in progress
//   doneLight  : last programming attempt succeeded
//   failLight  : last programming attempt failed
//   dbgState   : FSM state
//   dbgIndex   : current digit index
module password_programmer
  import password_pkg::*;
#(
  parameter logic [DIGITS*DIGIT_W-1:0] INIT_PW = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               prog,
  input  logic               abort,
  input  logic [IDX_W-1:0]   address,
  output logic [DIGIT_W-1:0] data,
  output logic               busy,
  output logic               doneLight,
  output logic               failLight,
  output logic [2:0]         dbgState,
  output logic [IDX_W-1:0]   dbgIndex
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DIGITS - 1);

  ProgState           r_state, w_state_d;
  logic [IDX_W-1:0]   r_index, w_index_d;
  logic               r_mismatch, w_mismatch_d;
  logic [DIGIT_W-1:0] r_shadow [DIGITS];
  logic               w_shadow_we;
  logic               w_commit;
  logic               w_bad_digit;
  logic               w_mm_acc;
  logic [DIGITS*DIGIT_W-1:0] w_shadow_flat;

  assign w_bad_digit = (digit > DIGIT_W'(MAX_DIGIT));
  // Mismatch including the digit on the bus, so the last digit counts.
  assign w_mm_acc    = r_mismatch | (digit != r_shadow[r_index]);

  always_comb begin
    w_state_d    = r_state;
    w_index_d    = r_index;
    w_mismatch_d = r_mismatch;
    w_shadow_we  = 1'b0;
    w_commit     = 1'b0;
    if (abort) begin
      w_state_d    = S_IDLE;
      w_index_d    = '0;
      w_mismatch_d = 1'b0;
    end else if (prog) begin
      w_state_d    = S_FIRST;
      w_index_d    = '0;
      w_mismatch_d = 1'b0;
    end else begin
      unique case (r_state)
        S_FIRST: begin
          if (enable) begin
            if (w_bad_digit) begin
              w_state_d = S_FAIL;
              w_index_d = '0;
            end else begin
              w_shadow_we = 1'b1;
              if (r_index == LastIdx) begin
                w_state_d = S_SECOND;
                w_index_d = '0;
              end else begin
                w_index_d = r_index + 1'b1;
              end
            end
          end
        end
        S_SECOND: begin
          if (enable) begin
            if (w_bad_digit) begin
              w_state_d = S_FAIL;
              w_index_d = '0;
            end else if (r_index == LastIdx) begin
              w_state_d    = w_mm_acc ? S_FAIL : S_COMMIT;
              w_index_d    = '0;
              w_mismatch_d = w_mm_acc;
            end else begin
              w_index_d    = r_index + 1'b1;
              w_mismatch_d = w_mm_acc;
            end
          end
        end
        S_COMMIT: begin
          w_commit  = 1'b1;
          w_state_d = S_DONE;
        end
        default: ;  // IDLE/DONE/FAIL wait for prog or abort
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_mismatch <= 1'b0;
      for (int i = 0; i < DIGITS; i++) r_shadow[i] <= '0;
    end else begin
      r_state    <= w_state_d;
      r_index    <= w_index_d;
      r_mismatch <= w_mismatch_d;
      if (w_shadow_we) r_shadow[r_index] <= digit;
    end
  end

  always_comb begin
    w_shadow_flat = '0;
    for (int i = 0; i < DIGITS; i++) w_shadow_flat[DIGIT_W*i +: DIGIT_W] = r_shadow[i];
  end

  password_regfile #(
    .INIT_PW (INIT_PW)
  ) u_regfile (
    .CLK     (CLK),
    .RST     (RST),
    .we      (w_commit),
    .wdata   (w_shadow_flat),
    .address (address),
    .data    (data)
  );

  assign busy      = (r_state == S_FIRST) || (r_state == S_SECOND) || (r_state == S_COMMIT);
  assign doneLight = (r_state == S_DONE);
  assign failLight = (r_state == S_FAIL);
  assign dbgState  = r_state;
  assign dbgIndex  = r_index;

endmodule
